// File: rtl/ccu_pkg.sv
// Shared CCU framing definitions: sync byte, packet type codes, header field
// widths and the return-path scheduler state encoding.
package ccu_pkg;

  localparam int ID_W  = 16;
  localparam int LEN_W = 13;

  localparam logic [7:0] CCU_SYNC_BYTE = 8'h5A;

  localparam logic [7:0] PACKAGE_TYPE_ADC_DATA   = 8'h12;
  localparam logic [7:0] PACKAGE_TYPE_DAC_RB     = 8'h22;
  localparam logic [7:0] PACKAGE_TYPE_SYS_STATUS = 8'h31;

  // One state per framed header byte, then payload and a one-cycle wrap-up.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SYNC    = 4'd1,
    ST_ID_LB   = 4'd2,
    ST_ID_HB   = 4'd3,
    ST_LEN_LB  = 4'd4,
    ST_LEN_HB  = 4'd5,
    ST_TYPE    = 4'd6,
    ST_PAYLOAD = 4'd7,
    ST_DONE    = 4'd8
  } tx_state_e;

  // Upper length byte on the wire: the 5 high length bits, zero padded.
  function automatic logic [7:0] len_hi_byte(input logic [LEN_W-1:0] len);
    return {3'b000, len[12:8]};
  endfunction

endpackage

// File: rtl/ccu_pack_arbiter_rr.sv
// Round-robin request picker. Purely combinational: returns the first
// requester at or after ptr, wrapping modulo N. The pointer register is
// owned by the instantiating block.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_pos;
  logic             w_found;

  // Scan the requesters in rotated order and keep the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_pos     = '0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        w_sum = {1'b0, ptr} + (IDX_W+1)'(k);
        if (w_sum >= (IDX_W+1)'(N)) begin
          w_sum = w_sum - (IDX_W+1)'(N);
        end
        w_pos = w_sum[IDX_W-1:0];
        if (!w_found && req[w_pos]) begin
          w_found      = 1'b1;
          grant[w_pos] = 1'b1;
          grant_idx    = w_pos;
        end
      end
    end
  end

endmodule

// File: rtl/ccu_pack_arbiter.sv
// Return-path scheduler: shares the SPI TX byte channel between N_SRC response
// sources in round-robin order and frames each granted response as
// 5A, id lo, id hi, len lo, len hi, type, payload.
//
// Handshakes: a byte moves to the SPI TX only in a cycle with txd_ready=1, and
// txd_load/txd_in are then asserted in that same cycle. A payload byte moves
// from source g only when txd_ready && src_dv[g]; src_rd[g] marks that cycle.
// src_req is a level; once granted, the latched header is used and later
// changes on src_req/src_id/src_len/src_type are ignored until DONE.
module ccu_pack_arbiter
  import ccu_pkg::*;
#(
  parameter int N_SRC   = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_SRC-1:0]       src_req,
  input  logic [16*N_SRC-1:0]    src_id,
  input  logic [13*N_SRC-1:0]    src_len,
  input  logic [8*N_SRC-1:0]     src_type,
  input  logic [8*N_SRC-1:0]     src_data,
  input  logic [N_SRC-1:0]       src_dv,
  output logic [N_SRC-1:0]       src_grant,
  output logic [N_SRC-1:0]       src_rd,
  output logic [N_SRC-1:0]       src_done,
  output logic [7:0]             txd_in,
  output logic                   txd_load,
  input  logic                   txd_ready,
  output logic                   busy,
  output logic                   err_timeout,
  output logic [3:0]             dbg_state
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  // Stall count value at which the next idle cycle completes TIMEOUT stalls.
  localparam logic [LEN_W-1:0] STALL_LAST = LEN_W'(TIMEOUT - 1);

  tx_state_e          r_state;
  tx_state_e          w_next;
  logic [N_SRC-1:0]   r_grant;
  logic [IDX_W-1:0]   r_gidx;
  logic [IDX_W-1:0]   r_ptr;
  logic [ID_W-1:0]    r_id;
  logic [LEN_W-1:0]   r_len;
  logic [7:0]         r_type;
  logic [LEN_W-1:0]   r_byte_ct;
  logic [LEN_W-1:0]   r_stall;
  logic               r_pad;
  logic               r_err;

  logic [N_SRC-1:0]   w_arb_grant;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_en;
  logic               w_start;
  logic [ID_W-1:0]    w_sel_id;
  logic [LEN_W-1:0]   w_sel_len;
  logic [7:0]         w_sel_type;
  logic [7:0]         w_cur_data;
  logic               w_cur_dv;
  logic [7:0]         w_hdr;
  logic               w_last;
  logic               w_load;
  logic [7:0]         w_txd;
  logic               w_rd_en;
  logic               w_done_en;
  logic               w_byte_inc;

  assign w_arb_en = (r_state == ST_IDLE);
  assign w_start  = w_arb_en && (|src_req);
  assign w_last   = (r_byte_ct == (r_len - LEN_W'(1)));

  rr_arbiter #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (src_req),
    .ptr       (r_ptr),
    .en        (w_arb_en),
    .grant     (w_arb_grant),
    .grant_idx (w_arb_idx)
  );

  // Select the header fields of the source being granted this cycle.
  always_comb begin
    w_sel_id   = '0;
    w_sel_len  = '0;
    w_sel_type = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_arb_grant[i]) begin
        w_sel_id   = src_id[ID_W*i +: ID_W];
        w_sel_len  = src_len[LEN_W*i +: LEN_W];
        w_sel_type = src_type[8*i +: 8];
      end
    end
  end

  // Route the granted source's payload byte and valid flag.
  always_comb begin
    w_cur_data = '0;
    w_cur_dv   = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_gidx == IDX_W'(i)) begin
        w_cur_data = src_data[8*i +: 8];
        w_cur_dv   = src_dv[i];
      end
    end
  end

  // Header byte for the current framing state.
  always_comb begin
    case (r_state)
      ST_SYNC:   w_hdr = CCU_SYNC_BYTE;
      ST_ID_LB:  w_hdr = r_id[7:0];
      ST_ID_HB:  w_hdr = r_id[15:8];
      ST_LEN_LB: w_hdr = r_len[7:0];
      ST_LEN_HB: w_hdr = len_hi_byte(r_len);
      ST_TYPE:   w_hdr = r_type;
      default:   w_hdr = 8'h00;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and per-cycle strobes; nothing leaves unless txd_ready is high.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_txd      = 8'h00;
    w_rd_en    = 1'b0;
    w_done_en  = 1'b0;
    w_byte_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|src_req) w_next = ST_SYNC;
      end
      ST_SYNC: begin
        if (txd_ready) begin
          w_load = 1'b1;
          w_txd  = w_hdr;
          w_next = ST_ID_LB;
        end
      end
      ST_ID_LB: begin
        if (txd_ready) begin
          w_load = 1'b1;
          w_txd  = w_hdr;
          w_next = ST_ID_HB;
        end
      end
      ST_ID_HB: begin
        if (txd_ready) begin
          w_load = 1'b1;
          w_txd  = w_hdr;
          w_next = ST_LEN_LB;
        end
      end
      ST_LEN_LB: begin
        if (txd_ready) begin
          w_load = 1'b1;
          w_txd  = w_hdr;
          w_next = ST_LEN_HB;
        end
      end
      ST_LEN_HB: begin
        if (txd_ready) begin
          w_load = 1'b1;
          w_txd  = w_hdr;
          w_next = ST_TYPE;
        end
      end
      ST_TYPE: begin
        if (txd_ready) begin
          w_load = 1'b1;
          w_txd  = w_hdr;
          if (r_len == '0) begin
            // Empty packet: the type byte is the last byte.
            w_done_en = 1'b1;
            w_next    = ST_DONE;
          end else begin
            w_next = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (r_pad) begin
          // Source gave up: fill the remaining length with zeros.
          if (txd_ready) begin
            w_load     = 1'b1;
            w_txd      = 8'h00;
            w_byte_inc = 1'b1;
            if (w_last) begin
              w_done_en = 1'b1;
              w_next    = ST_DONE;
            end
          end
        end else if (txd_ready && w_cur_dv) begin
          w_load     = 1'b1;
          w_txd      = w_cur_data;
          w_rd_en    = 1'b1;
          w_byte_inc = 1'b1;
          if (w_last) begin
            w_done_en = 1'b1;
            w_next    = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Grant, latched header and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_id    <= '0;
      r_len   <= '0;
      r_type  <= '0;
    end else if (w_start) begin
      r_grant <= w_arb_grant;
      r_gidx  <= w_arb_idx;
      r_id    <= w_sel_id;
      r_len   <= w_sel_len;
      r_type  <= w_sel_type;
    end else if (r_state == ST_DONE) begin
      r_grant <= '0;
      r_ptr   <= (r_gidx == IDX_W'(N_SRC - 1)) ? '0 : r_gidx + IDX_W'(1);
    end
  end

  // Payload byte counter, stall counter, pad mode and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_byte_ct <= '0;
      r_stall   <= '0;
      r_pad     <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_start) begin
      r_byte_ct <= '0;
      r_stall   <= '0;
      r_pad     <= 1'b0;
    end else if (w_byte_inc) begin
      r_byte_ct <= r_byte_ct + LEN_W'(1);
      r_stall   <= '0;
    end else if ((r_state == ST_PAYLOAD) && !r_pad && !w_cur_dv) begin
      r_stall <= r_stall + LEN_W'(1);
      if (r_stall == STALL_LAST) begin
        r_pad <= 1'b1;
        r_err <= 1'b1;
      end
    end
  end

  assign src_grant   = r_grant;
  assign src_rd      = w_rd_en   ? r_grant : '0;
  assign src_done    = w_done_en ? r_grant : '0;
  assign txd_load    = w_load;
  assign txd_in      = w_txd;
  assign busy        = |r_grant;
  assign err_timeout = r_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ccu_pack_arbiter.sv
// Directed bench for the CCU return-path scheduler: framing, round-robin order,
// empty packets, TX back-pressure, payload timeout padding and mid-packet reset.
module tb_ccu_pack_arbiter;

  localparam int N = 3;
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_SYNC    = 4'd1;
  localparam logic [3:0] S_PAYLOAD = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    src_req;
  logic [16*N-1:0] src_id;
  logic [13*N-1:0] src_len;
  logic [8*N-1:0]  src_type;
  logic [8*N-1:0]  src_data;
  logic [N-1:0]    src_dv;
  logic [N-1:0]    src_grant;
  logic [N-1:0]    src_rd;
  logic [N-1:0]    src_done;
  logic [7:0]      txd_in;
  logic            txd_load;
  logic            txd_ready;
  logic            busy;
  logic            err_timeout;
  logic [3:0]      dbg_state;

  always #5 clk = ~clk;

  ccu_pack_arbiter #(.N_SRC(N), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .src_req(src_req), .src_id(src_id), .src_len(src_len),
    .src_type(src_type), .src_data(src_data), .src_dv(src_dv), .src_grant(src_grant),
    .src_rd(src_rd), .src_done(src_done), .txd_in(txd_in), .txd_load(txd_load),
    .txd_ready(txd_ready), .busy(busy), .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // ---------------- source model state ----------------
  logic [7:0] pay [N][16];
  int         avail   [N];
  int         rd_base [N];
  int         rd_tot  [N];
  bit         tog_mode;

  // ---------------- monitor records ----------------
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         ld_cyc[$];
  int         gnt_q[$];
  int         done_src_q[$];
  int         done_pos_q[$];
  int         bad_ld, nr_cyc, onehot_bad, cyc;
  int         b_got, b_gnt, b_done, b_bad, b_nr;
  int         n_checks, n_errors;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    b_got  = got_q.size();
    b_gnt  = gnt_q.size();
    b_done = done_src_q.size();
    b_bad  = bad_ld;
    b_nr   = nr_cyc;
  endtask

  // Load n expected bytes, first byte in the most significant position.
  task automatic load_exp(input int n, input logic [255:0] v);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(v[8*(n-1-k) +: 8]);
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_nbytes"}, got_q.size() - b_got, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (b_got + k < got_q.size())
        check($sformatf("%s_byte%0d", tag, k), got_q[b_got + k], exp_q[k]);
    end
  endtask

  function automatic int cyc_gap(input int a, input int b);
    if (ld_cyc.size() > b_got + b) return ld_cyc[b_got + b] - ld_cyc[b_got + a];
    return -1;
  endfunction

  task automatic check_done(input string tag, input int src, input int pos);
    check({tag, "_done_n"}, done_src_q.size() - b_done, 1);
    if (done_src_q.size() > b_done) begin
      check({tag, "_done_src"}, done_src_q[b_done], src);
      check({tag, "_done_pos"}, done_pos_q[b_done] - b_got, pos);
    end
  endtask

  task automatic set_src(input int s, input logic [15:0] id, input logic [12:0] len,
                         input logic [7:0] typ, input int av);
    src_id[16*s +: 16]  = id;
    src_len[13*s +: 13] = len;
    src_type[8*s +: 8]  = typ;
    avail[s]            = av;
    rd_base[s]          = rd_tot[s];
  endtask

  task automatic wait_state(input string tag, input logic [3:0] st, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (dbg_state == st) seen = 1'b1;
    end
    check(tag, seen, 1'b1);
  endtask

  task automatic wait_pkt(input string tag);
    wait_state(tag, S_DONE, 300);
    @(negedge clk);
  endtask

  // ---------------- monitor: sample outputs on the falling edge ----------------
  initial begin
    logic [N-1:0] prev_gnt;
    prev_gnt = '0;
    cyc = 0; bad_ld = 0; nr_cyc = 0; onehot_bad = 0;
    for (int i = 0; i < N; i++) rd_tot[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!txd_ready) nr_cyc++;
      if (txd_load) begin
        got_q.push_back(txd_in);
        ld_cyc.push_back(cyc);
        if (!txd_ready) bad_ld++;
      end
      for (int i = 0; i < N; i++) begin
        if (src_rd[i]) rd_tot[i]++;
        if (src_done[i]) begin
          done_src_q.push_back(i);
          done_pos_q.push_back(got_q.size());
        end
      end
      if (!$onehot0(src_grant) || !$onehot0(src_rd) || !$onehot0(src_done)) onehot_bad++;
      if (src_grant != '0 && prev_gnt == '0) begin
        for (int i = 0; i < N; i++) if (src_grant[i]) gnt_q.push_back(i);
      end
      prev_gnt = src_grant;
    end
  end

  // ---------------- driver: source data and TX ready, just after the edge ----------------
  initial begin
    int ix;
    txd_ready = 1'b1;
    src_dv    = '0;
    src_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        ix = rd_tot[i] - rd_base[i];
        src_data[8*i +: 8] = (ix < 16) ? pay[i][ix] : 8'h00;
        src_dv[i]          = (ix < avail[i]);
      end
      txd_ready = tog_mode ? ~txd_ready : 1'b1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    n_checks = 0; n_errors = 0;
    rstn = 1'b0; src_req = '0; src_id = '0; src_len = '0; src_type = '0; tog_mode = 1'b0;
    for (int i = 0; i < N; i++) begin
      avail[i] = 0; rd_base[i] = 0;
      for (int j = 0; j < 16; j++) pay[i][j] = 8'h00;
    end
    b_got = 0; b_gnt = 0; b_done = 0; b_bad = 0; b_nr = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_state", dbg_state, S_IDLE);
    check("rst_grant", src_grant, 3'b000);
    check("rst_load", txd_load, 1'b0);
    check("rst_txd", txd_in, 8'h00);
    check("rst_rd_done", {src_rd, src_done}, 6'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    rstn = 1'b1;
    @(negedge clk);

    // T1: basic framing, source 0, len 2
    set_src(0, 16'h1234, 13'd2, 8'h12, 2);
    pay[0][0] = 8'hAA; pay[0][1] = 8'hBB;
    mark();
    src_req = 3'b001;
    @(negedge clk);
    check("t1_grant", src_grant, 3'b001);
    check("t1_busy", busy, 1'b1);
    check("t1_first_load", {txd_load, txd_in}, {1'b1, 8'h5A});
    src_req = 3'b000;
    src_id[15:0] = 16'hFFFF;
    src_len[12:0] = 13'd9;
    wait_pkt("t1_wait");
    load_exp(8, 256'h5A341202_0012AABB);
    cmp_stream("t1");
    check("t1_span", cyc_gap(0, 7), 7);
    check("t1_rd", rd_tot[0] - rd_base[0], 2);
    check_done("t1", 0, 8);
    check("t1_idle_grant", src_grant, 3'b000);

    // T2: all three requesting, round-robin from a fresh pointer
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    set_src(0, 16'h0100, 13'd1, 8'h12, 16);
    set_src(1, 16'h0201, 13'd1, 8'h22, 16);
    set_src(2, 16'h0302, 13'd1, 8'h31, 16);
    pay[0][0] = 8'h10; pay[0][1] = 8'h11; pay[1][0] = 8'h21; pay[2][0] = 8'h32;
    mark();
    src_req = 3'b111;
    repeat (3) wait_pkt("t2_wait");
    wait_state("t2_fourth_start", S_SYNC, 10);
    src_req = 3'b000;
    wait_pkt("t2_wait4");
    load_exp(28, 256'h5A000101001210_5A010201002221_5A020301003132_5A000101001211);
    cmp_stream("t2");
    check("t2_ngrants", gnt_q.size() - b_gnt, 4);
    if (gnt_q.size() >= b_gnt + 4) begin
      check("t2_g0", gnt_q[b_gnt + 0], 0);
      check("t2_g1", gnt_q[b_gnt + 1], 1);
      check("t2_g2", gnt_q[b_gnt + 2], 2);
      check("t2_g3", gnt_q[b_gnt + 3], 0);
      for (int k = 1; k < 4; k++)
        check($sformatf("t2_norepeat%0d", k), gnt_q[b_gnt + k] != gnt_q[b_gnt + k - 1], 1'b1);
    end

    // T3: empty packet from source 1
    set_src(1, 16'hBEEF, 13'd0, 8'h22, 0);
    mark();
    src_req = 3'b010;
    @(negedge clk);
    check("t3_grant", src_grant, 3'b010);
    src_req = 3'b000;
    wait_pkt("t3_wait");
    load_exp(6, 256'h5AEFBE000022);
    cmp_stream("t3");
    check("t3_rd", rd_tot[1] - rd_base[1], 0);
    check_done("t3", 1, 6);

    // T4: T1 packet with txd_ready toggling every cycle
    set_src(0, 16'h1234, 13'd2, 8'h12, 2);
    pay[0][0] = 8'hAA; pay[0][1] = 8'hBB;
    mark();
    tog_mode = 1'b1;
    src_req = 3'b001;
    @(negedge clk);
    src_req = 3'b000;
    wait_pkt("t4_wait");
    tog_mode = 1'b0;
    load_exp(8, 256'h5A341202_0012AABB);
    cmp_stream("t4");
    check("t4_load_not_ready", bad_ld - b_bad, 0);
    check("t4_ready_low_seen", (nr_cyc - b_nr) > 0, 1'b1);
    check_done("t4", 0, 8);

    // T5: payload timeout after one byte, len 4
    set_src(2, 16'h0A0B, 13'd4, 8'h31, 1);
    pay[2][0] = 8'hCC;
    mark();
    src_req = 3'b100;
    @(negedge clk);
    check("t5_grant", src_grant, 3'b100);
    check("t5_err_before", err_timeout, 1'b0);
    src_req = 3'b000;
    wait_pkt("t5_wait");
    load_exp(10, 256'h5A0B0A04_0031CC00_0000);
    cmp_stream("t5");
    check("t5_stall_gap", cyc_gap(6, 7), 17);
    check("t5_err", err_timeout, 1'b1);
    check("t5_rd", rd_tot[2] - rd_base[2], 1);
    check_done("t5", 2, 10);

    // T5b: next request is served normally, timeout flag stays set
    set_src(0, 16'h0102, 13'd1, 8'h12, 16);
    pay[0][0] = 8'h5C;
    mark();
    src_req = 3'b001;
    @(negedge clk);
    check("t5b_grant", src_grant, 3'b001);
    src_req = 3'b000;
    wait_pkt("t5b_wait");
    load_exp(7, 256'h5A020101_00125C);
    cmp_stream("t5b");
    check("t5b_err_sticky", err_timeout, 1'b1);

    // T6: reset during payload
    set_src(1, 16'h0304, 13'd4, 8'h22, 16);
    pay[1][0] = 8'h41; pay[1][1] = 8'h42; pay[1][2] = 8'h43; pay[1][3] = 8'h44;
    src_req = 3'b010;
    @(negedge clk);
    src_req = 3'b000;
    wait_state("t6_reach_payload", S_PAYLOAD, 50);
    rstn = 1'b0;
    @(negedge clk);
    check("t6_state", dbg_state, S_IDLE);
    check("t6_grant", src_grant, 3'b000);
    check("t6_load", {txd_load, txd_in}, 9'h000);
    check("t6_rd_done", {src_rd, src_done}, 6'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_err", err_timeout, 1'b0);
    rstn = 1'b1;
    set_src(0, 16'h5566, 13'd1, 8'h12, 16);
    set_src(2, 16'h0909, 13'd1, 8'h31, 16);
    pay[0][0] = 8'h77;
    mark();
    src_req = 3'b101;
    @(negedge clk);
    check("t6_rr_from_zero", src_grant, 3'b001);
    src_req = 3'b000;
    wait_pkt("t6_wait");
    load_exp(7, 256'h5A665501_001277);
    cmp_stream("t6");

    check("onehot_all_run", onehot_bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
